// File: rtl/hist_accum_stage_pkg.sv
// Shared definitions for the equalisation pipeline stages.
// Holds the histogram geometry, FSM encoding and bank address helper.
package hist_accum_stage_pkg;

  localparam int PIX_W    = 8;
  localparam int CNT_W    = 20;
  localparam int NUM_BINS = 1 << PIX_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    DRAIN,
    FIN
  } histState_t;

  // Scratchpad address of one bin inside the selected histogram bank.
  function automatic logic [PIX_W:0] bankAddr(input logic bank, input logic [PIX_W-1:0] bin);
    return {bank, bin};
  endfunction

endpackage

// File: rtl/hist_accum_stage_rmw_pipe.sv
// Read-modify-write increment pipe for histogram bins.
// Forwards the two most recent writes so repeated bins count correctly.
module hist_rmw_pipe
  import hist_accum_stage_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int VAL_W = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic [BIN_W-1:0] inBin,
  input  logic [VAL_W-1:0] rdVal,
  output logic             wrEn,
  output logic [BIN_W-1:0] wrBin,
  output logic [VAL_W-1:0] wrVal
);

  logic             calcValid;
  logic [BIN_W-1:0] calcBin;
  logic             prevValid;
  logic [BIN_W-1:0] prevBin;
  logic [VAL_W-1:0] prevVal;
  logic [VAL_W-1:0] baseVal;
  logic [VAL_W-1:0] incVal;

  // The write committed last cycle is not yet visible in rdVal (same-edge read returns old data).
  always_comb begin
    baseVal = rdVal;
    if (wrEn && (wrBin == calcBin)) begin
      baseVal = wrVal;
    end else if (prevValid && (prevBin == calcBin)) begin
      baseVal = prevVal;
    end
    incVal = (baseVal == {VAL_W{1'b1}}) ? baseVal : baseVal + VAL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      calcValid <= 1'b0;
      calcBin   <= '0;
      wrEn      <= 1'b0;
      wrBin     <= '0;
      wrVal     <= '0;
      prevValid <= 1'b0;
      prevBin   <= '0;
      prevVal   <= '0;
    end else begin
      calcValid <= inValid;
      calcBin   <= inBin;
      wrEn      <= calcValid;
      wrBin     <= calcBin;
      wrVal     <= incVal;
      prevValid <= wrEn;
      prevBin   <= wrBin;
      prevVal   <= wrVal;
    end
  end

endmodule

// File: rtl/hist_accum_stage.sv
// Histogram accumulation stage: clears one M2 bank, then counts every M1 pixel.
// Pulses done once the final bin increment has been committed.
module hist_accum_stage
  import hist_accum_stage_pkg::*;
#(
  parameter int PIX_W      = hist_accum_stage_pkg::PIX_W,
  parameter int CNT_W      = hist_accum_stage_pkg::CNT_W,
  parameter int NUM_PIXELS = 76800,
  parameter int M1_AW      = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             inputBaseOffset,
  input  logic [PIX_W-1:0] m1ReadVal,
  output logic [M1_AW-1:0] m1ReadAddr,
  input  logic [CNT_W-1:0] m2ReadVal,
  output logic [PIX_W:0]   m2ReadAddr,
  output logic [PIX_W:0]   m2WriteAddr,
  output logic [CNT_W-1:0] m2WriteVal,
  output logic             m2WE,
  output logic             busy,
  output logic             done
);

  localparam logic [M1_AW-1:0] LAST_ADDR = M1_AW'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0] LAST_BIN  = PIX_W'(NUM_BINS - 1);

  histState_t       state;
  logic             bank;
  logic             clrWe;
  logic [PIX_W-1:0] clrBin;
  logic             issue;
  logic             rdValid;
  logic [M1_AW-1:0] m1Addr;
  logic [1:0]       drainCnt;
  logic             busyReg;
  logic             doneReg;

  logic             pipeWe;
  logic [PIX_W-1:0] pipeBin;
  logic [CNT_W-1:0] pipeVal;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bank     <= 1'b0;
      clrWe    <= 1'b0;
      clrBin   <= '0;
      issue    <= 1'b0;
      rdValid  <= 1'b0;
      m1Addr   <= '0;
      drainCnt <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      rdValid <= issue;
      unique case (state)
        IDLE: begin
          if (start) begin
            bank    <= inputBaseOffset;
            busyReg <= 1'b1;
            clrWe   <= 1'b1;
            clrBin  <= '0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (clrBin == LAST_BIN) begin
            clrWe  <= 1'b0;
            issue  <= 1'b1;
            m1Addr <= '0;
            state  <= COUNT;
          end else begin
            clrBin <= clrBin + PIX_W'(1);
          end
        end
        COUNT: begin
          if (m1Addr == LAST_ADDR) begin
            issue    <= 1'b0;
            drainCnt <= '0;
            state    <= DRAIN;
          end else begin
            m1Addr <= m1Addr + M1_AW'(1);
          end
        end
        DRAIN: begin
          // Three cycles cover read, compute and write of the final pixel.
          if (drainCnt == 2'd2) begin
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            state   <= FIN;
          end else begin
            drainCnt <= drainCnt + 2'd1;
          end
        end
        FIN: begin
          doneReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hist_rmw_pipe #(
    .BIN_W(PIX_W),
    .VAL_W(CNT_W)
  ) rmwPipe (
    .clock  (clock),
    .reset  (reset),
    .inValid(rdValid),
    .inBin  (m1ReadVal),
    .rdVal  (m2ReadVal),
    .wrEn   (pipeWe),
    .wrBin  (pipeBin),
    .wrVal  (pipeVal)
  );

  assign m1ReadAddr = m1Addr;
  assign m2ReadAddr = rdValid ? bankAddr(bank, m1ReadVal) : '0;
  assign m2WE       = clrWe | pipeWe;
  assign m2WriteVal = pipeWe ? pipeVal : '0;
  always_comb begin
    m2WriteAddr = '0;
    if (pipeWe) begin
      m2WriteAddr = bankAddr(bank, pipeBin);
    end else if (clrWe) begin
      m2WriteAddr = bankAddr(bank, clrBin);
    end
  end
  assign busy = busyReg;
  assign done = doneReg;

endmodule

// File: tb/tb_hist_accum_stage.sv
// Bench for hist_accum_stage: small frames with a narrow counter so saturation is reachable.
// Memories are modelled here; expected bank contents come from a plain histogram model.
module tb_hist_accum_stage;

  localparam int NPIX     = 20;
  localparam int CW       = 4;
  localparam int AW       = 5;
  localparam int CMAX     = (1 << CW) - 1;
  localparam int DONE_CYC = 256 + NPIX + 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          inputBaseOffset;
  logic [7:0]    m1ReadVal;
  logic [AW-1:0] m1ReadAddr;
  logic [CW-1:0] m2ReadVal;
  logic [8:0]    m2ReadAddr;
  logic [8:0]    m2WriteAddr;
  logic [CW-1:0] m2WriteVal;
  logic          m2WE;
  logic          busy;
  logic          done;

  logic [7:0]    img     [0:31];
  logic [CW-1:0] mem     [0:511];
  logic [CW-1:0] seedMem [0:511];
  logic [CW-1:0] expMem  [0:511];
  logic          loadMem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            bank;
    int              toggleAt;
    int              restartAt;
    logic [19:0][7:0] pix;
    int              pA;
    int              eA;
    int              pB;
    int              eB;
  } vec_t;

  vec_t tbl [5];

  always #5 clock = ~clock;

  hist_accum_stage #(
    .CNT_W(CW),
    .NUM_PIXELS(NPIX),
    .M1_AW(AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .inputBaseOffset(inputBaseOffset),
    .m1ReadVal      (m1ReadVal),
    .m1ReadAddr     (m1ReadAddr),
    .m2ReadVal      (m2ReadVal),
    .m2ReadAddr     (m2ReadAddr),
    .m2WriteAddr    (m2WriteAddr),
    .m2WriteVal     (m2WriteVal),
    .m2WE           (m2WE),
    .busy           (busy),
    .done           (done)
  );

  // Synchronous memories: one-cycle read latency, same-edge read returns old data.
  always @(posedge clock) begin
    m1ReadVal <= img[m1ReadAddr];
    m2ReadVal <= mem[m2ReadAddr];
    if (loadMem) begin
      for (int i = 0; i < 512; i++) mem[i] <= seedMem[i];
    end else if (m2WE) begin
      mem[m2WriteAddr] <= m2WriteVal;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: saturating count of each pixel value, written into the chosen bank.
  task automatic modelBank(input logic bnk);
    int h [256];
    for (int b = 0; b < 256; b++) h[b] = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (h[img[i]] < CMAX) h[img[i]]++;
    end
    for (int b = 0; b < 256; b++) expMem[{bnk, 8'(b)}] = CW'(h[b]);
  endtask

  task automatic compareMem(input string name);
    int bad = 0;
    for (int a = 0; a < 512; a++) begin
      if (mem[a] !== expMem[a]) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic runFrame(input logic bnk, input int toggleAt, input int restartAt, input int abortAt);
    int clrBad = 0;
    int ctrlBad = 0;
    int addrBad = 0;
    int bankBad = 0;
    int nWr = 0;
    int nDone = 0;
    @(negedge clock);
    start = 1'b1;
    inputBaseOffset = bnk;
    for (int k = 1; k <= DONE_CYC + 2; k++) begin
      @(negedge clock);
      start = (k == restartAt);
      if (k == toggleAt) inputBaseOffset = ~bnk;
      if (k <= 256) begin
        if (!(m2WE === 1'b1 && m2WriteAddr === {bnk, 8'(k - 1)} && m2WriteVal === '0)) clrBad++;
      end else if (m2WE === 1'b1) begin
        nWr++;
        if (m2WriteAddr[8] !== bnk) bankBad++;
      end
      if (busy !== (k < DONE_CYC)) ctrlBad++;
      if (done === 1'b1) nDone++;
      if (done !== (k == DONE_CYC)) ctrlBad++;
      if (k >= 257 && k < 257 + NPIX && m1ReadAddr !== AW'(k - 257)) addrBad++;
      if (k == abortAt) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        check("abortOutputs", {m2WE, busy, done}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("abortNextCycle", {m2WE, busy, done}, 0);
        $display("frame bank %0d aborted at cycle %0d", bnk, k);
        return;
      end
    end
    start = 1'b0;
    inputBaseOffset = 1'b0;
    check("clearSequence", clrBad, 0);
    check("busyDoneTiming", ctrlBad, 0);
    check("m1AddrSequence", addrBad, 0);
    check("bankSelect", bankBad, 0);
    check("pixelWrites", nWr, NPIX);
    check("donePulses", nDone, 1);
    $display("frame bank %0d: %0d writes, %0d done pulses", bnk, nWr, nDone);
  endtask

  initial begin
    int flag;
    reset = 1'b1;
    start = 1'b0;
    inputBaseOffset = 1'b0;
    loadMem = 1'b1;
    for (int i = 0; i < 32; i++) img[i] = 8'd0;
    for (int a = 0; a < 512; a++) begin
      seedMem[a] = CW'($urandom_range(0, CMAX));
      expMem[a] = seedMem[a];
    end

    // Vector table: hand-picked frames with known bin counts.
    for (int r = 0; r < 5; r++) begin
      tbl[r].toggleAt = -1;
      tbl[r].restartAt = -1;
      for (int i = 0; i < 20; i++) tbl[r].pix[i] = 8'd0;
    end
    tbl[0].bank = 1'b0; tbl[0].pA = 0; tbl[0].eA = 15; tbl[0].pB = 1; tbl[0].eB = 0;
    tbl[1].bank = 1'b0; tbl[1].pA = 5; tbl[1].eA = 4; tbl[1].pB = 7; tbl[1].eB = 3;
    for (int i = 0; i < 20; i++) tbl[1].pix[i] = 8'd200;
    tbl[1].pix[0] = 8'd5; tbl[1].pix[1] = 8'd5; tbl[1].pix[2] = 8'd5; tbl[1].pix[3] = 8'd7;
    tbl[1].pix[4] = 8'd5; tbl[1].pix[5] = 8'd7; tbl[1].pix[6] = 8'd7;
    tbl[2].bank = 1'b1; tbl[2].toggleAt = 262; tbl[2].pA = 0; tbl[2].eA = 5; tbl[2].pB = 3; tbl[2].eB = 5;
    for (int i = 0; i < 20; i++) tbl[2].pix[i] = 8'(i % 4);
    tbl[3].bank = 1'b0; tbl[3].pA = 9; tbl[3].eA = 15; tbl[3].pB = 8; tbl[3].eB = 0;
    for (int i = 0; i < 20; i++) tbl[3].pix[i] = 8'd9;
    tbl[4].bank = 1'b1; tbl[4].restartAt = 50; tbl[4].pA = 0; tbl[4].eA = 7; tbl[4].pB = 2; tbl[4].eB = 6;
    for (int i = 0; i < 20; i++) tbl[4].pix[i] = 8'(i % 3);

    repeat (3) @(negedge clock);
    check("resetOutputs", {m1ReadAddr, m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE, busy, done}, 0);
    loadMem = 1'b0;

    // Start coincident with reset must be ignored.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    flag = 0;
    repeat (3) begin
      @(negedge clock);
      if ({m2WE, busy, done} !== 3'b000) flag++;
    end
    check("resetBeatsStart", flag, 0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 20; i++) img[i] = tbl[r].pix[i];
      runFrame(tbl[r].bank, tbl[r].toggleAt, tbl[r].restartAt, -1);
      modelBank(tbl[r].bank);
      compareMem("tableMemImage");
      check("tableProbeA", mem[{tbl[r].bank, 8'(tbl[r].pA)}], tbl[r].eA);
      check("tableProbeB", mem[{tbl[r].bank, 8'(tbl[r].pB)}], tbl[r].eB);
    end

    // Abort mid-COUNT, then a fresh frame on the same bank must fully recover.
    for (int i = 0; i < 20; i++) img[i] = 8'($urandom_range(0, 5));
    runFrame(1'b0, -1, -1, 256 + 10);
    runFrame(1'b0, -1, -1, -1);
    modelBank(1'b0);
    compareMem("afterAbortMemImage");

    for (int it = 0; it < 6; it++) begin
      logic bnk;
      bnk = 1'($urandom_range(0, 1));
      for (int i = 0; i < 20; i++) begin
        case (it % 3)
          0: img[i] = 8'($urandom_range(0, 255));
          1: img[i] = 8'($urandom_range(0, 7));
          default: img[i] = 8'($urandom_range(0, 1) * 17);
        endcase
      end
      runFrame(bnk, -1, -1, -1);
      modelBank(bnk);
      compareMem("randomMemImage");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
